swizzle_stream: RTL

Sequential, parametrised successor to the single-beat scratchpad swizzle descriptor logic. It accepts one tile request (base scratchpad row, tile extent, row- or column-major orientation, swizzle mode). It then streams one crossbar descriptor per row or column beat over a valid/ready interface until the tile is exhausted. It sits between the scratchpad request front-end and the bank crossbar. Runtime XOR-or-identity mode and flush are features the single-beat version lacks.

---
 rtl/scpad_pkg.sv | 33 +++
 rtl/swizzle_lane_calc.sv | 31 +++
 rtl/swizzle_stream.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/scpad_pkg.sv
// Shared types and default geometry for the scratchpad swizzle stream.
package scpad_pkg;

    localparam int NUM_COLS  = 32;
    localparam int NUM_ROWS  = 1024;
    localparam int COL_IDX_W = $clog2(NUM_COLS);
    localparam int ROW_IDX_W = $clog2(NUM_ROWS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } swizzle_state_t;

    typedef struct packed {
        logic [NUM_COLS-1:0]           valid;
        logic [NUM_COLS*COL_IDX_W-1:0] shift;
        logic [NUM_COLS*ROW_IDX_W-1:0] slot;
    } xbar_desc_t;

    typedef struct packed {
        logic [ROW_IDX_W-1:0] spad_addr;
        logic [COL_IDX_W-1:0] num_rows;
        logic [COL_IDX_W-1:0] num_cols;
        logic                 row_or_col;
        logic                 xor_en;
    } swizzle_req_t;

    // Index of the final beat: rows in row-major, columns in column-major.
    function automatic logic [COL_IDX_W-1:0] last_beat_idx(input swizzle_req_t r);
        return r.row_or_col ? r.num_rows : r.num_cols;
    endfunction

endpackage

// File: rtl/swizzle_lane_calc.sv
// Combinational per-lane descriptor field: enable, bank shift and slot row for one lane.
module swizzle_lane_calc #(
    parameter int COL_IDX_W = 5,
    parameter int ROW_IDX_W = 10
) (
    input  logic [COL_IDX_W-1:0] lane,
    input  logic [COL_IDX_W-1:0] beat,
    input  logic [ROW_IDX_W-1:0] spad_addr,
    input  logic [COL_IDX_W-1:0] num_rows,
    input  logic [COL_IDX_W-1:0] num_cols,
    input  logic                 row_or_col,
    input  logic                 xor_en,
    output logic                 valid,
    output logic [COL_IDX_W-1:0] shift,
    output logic [ROW_IDX_W-1:0] slot
);

    logic [ROW_IDX_W-1:0] offs;
    logic [ROW_IDX_W-1:0] abs_addr;
    logic [COL_IDX_W-1:0] idx;

    // Row-major walks the beat down the rows; column-major spreads lanes across rows.
    assign offs     = ROW_IDX_W'(row_or_col ? beat : lane);
    assign abs_addr = spad_addr + offs;
    assign idx      = row_or_col ? lane : beat;

    assign valid = row_or_col ? (lane <= num_cols) : (lane <= num_rows);
    assign shift = xor_en ? (idx ^ abs_addr[COL_IDX_W-1:0]) : idx;
    assign slot  = abs_addr;

endmodule

// File: rtl/swizzle_stream.sv
// Streams one crossbar descriptor per tile beat; SWIZZLE_STREAM_PERF_EN adds tile/stall counters.
//  state | meaning
//  IDLE  | ready for a tile request, no descriptor presented
//  RUN   | presenting desc_* for beat desc_beat until the last one is taken
module swizzle_stream
    import scpad_pkg::*;
#(
    parameter int NUM_COLS  = scpad_pkg::NUM_COLS,
    parameter int NUM_ROWS  = scpad_pkg::NUM_ROWS,
    parameter int COL_IDX_W = $clog2(NUM_COLS),
    parameter int ROW_IDX_W = $clog2(NUM_ROWS)
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           flush,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ROW_IDX_W-1:0]           req_spad_addr,
    input  logic [COL_IDX_W-1:0]           req_num_rows,
    input  logic [COL_IDX_W-1:0]           req_num_cols,
    input  logic                           req_row_or_col,
    input  logic                           req_xor_en,
    output logic                           desc_valid,
    input  logic                           desc_ready,
    output logic [NUM_COLS-1:0]            desc_valid_mask,
    output logic [NUM_COLS*COL_IDX_W-1:0]  desc_shift_mask,
    output logic [NUM_COLS*ROW_IDX_W-1:0]  desc_slot_mask,
    output logic [COL_IDX_W-1:0]           desc_beat,
    output logic                           desc_last,
    output logic                           busy
`ifdef SWIZZLE_STREAM_PERF_EN
    ,
    output logic [31:0]                    perf_tiles,
    output logic [31:0]                    perf_stalls
`endif
);

    swizzle_state_t state_q, state_d;
    swizzle_req_t   req_q, src;
    logic [COL_IDX_W-1:0] beat_q, beat_src;
    logic                 last_q, last_d;
    xbar_desc_t           desc_q;

    logic [NUM_COLS-1:0]           valid_d;
    logic [NUM_COLS*COL_IDX_W-1:0] shift_d;
    logic [NUM_COLS*ROW_IDX_W-1:0] slot_d;

    logic hs, accept, advance;

    assign hs      = (state_q == RUN) && desc_ready;
    assign accept  = (state_q == IDLE) && req_valid && !flush;
    assign advance = hs && !last_q && !flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (req_valid) state_d = RUN;
                RUN:     if (desc_ready && last_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        desc_valid = (state_q == RUN);
        busy       = (state_q != IDLE);
    end

    // In IDLE the lanes evaluate beat 0 of the incoming request, otherwise the next beat of the latched one.
    always_comb begin
        src      = req_q;
        beat_src = beat_q + 1'b1;
        if (state_q == IDLE) begin
            src.spad_addr  = req_spad_addr;
            src.num_rows   = req_num_rows;
            src.num_cols   = req_num_cols;
            src.row_or_col = req_row_or_col;
            src.xor_en     = req_xor_en;
            beat_src       = '0;
        end
        last_d = (beat_src == last_beat_idx(src));
    end

    for (genvar k = 0; k < NUM_COLS; k++) begin : g_lane
        swizzle_lane_calc #(
            .COL_IDX_W (COL_IDX_W),
            .ROW_IDX_W (ROW_IDX_W)
        ) u_lane (
            .lane       (COL_IDX_W'(k)),
            .beat       (beat_src),
            .spad_addr  (src.spad_addr),
            .num_rows   (src.num_rows),
            .num_cols   (src.num_cols),
            .row_or_col (src.row_or_col),
            .xor_en     (src.xor_en),
            .valid      (valid_d[k]),
            .shift      (shift_d[k*COL_IDX_W +: COL_IDX_W]),
            .slot       (slot_d[k*ROW_IDX_W +: ROW_IDX_W])
        );
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_q  <= '0;
            beat_q <= '0;
            last_q <= 1'b0;
            desc_q <= '0;
        end else if (accept || advance) begin
            if (accept) req_q <= src;
            beat_q       <= beat_src;
            last_q       <= last_d;
            desc_q.valid <= valid_d;
            desc_q.shift <= shift_d;
            desc_q.slot  <= slot_d;
        end
    end

    assign desc_valid_mask = desc_q.valid;
    assign desc_shift_mask = desc_q.shift;
    assign desc_slot_mask  = desc_q.slot;
    assign desc_beat       = beat_q;
    assign desc_last       = last_q;

`ifdef SWIZZLE_STREAM_PERF_EN
    // Counters survive flush so software can read totals across aborted tiles.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_tiles  <= '0;
            perf_stalls <= '0;
        end else begin
            if (hs && last_q)             perf_tiles  <= perf_tiles + 32'd1;
            if (desc_valid && !desc_ready) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule
